// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read master (AR/R) among NREQ cache-line refill requesters.
// Round-robin AR issue with ARID = requester index; R beats are routed back by RID
// with one cycle of registered latency, so beats of different requesters may interleave.
module axi_rd_arbiter #(
  parameter int NREQ           = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int BURST_LEN      = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ*AXI_ADDR_WIDTH-1:0] req_addr,
  output logic [NREQ-1:0]                rsp_valid,
  output logic [AXI_DATA_WIDTH-1:0]      rsp_data,
  output logic                           rsp_last,
  output logic                           rsp_err,
  output logic                           stray_rid,
  output logic [AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
  output logic                           M_AXI_ARVALID,
  input  logic                           M_AXI_ARREADY,
  output logic [AXI_ID_WIDTH-1:0]        M_AXI_ARID,
  output logic [1:0]                     M_AXI_ARBURST,
  output logic [2:0]                     M_AXI_ARSIZE,
  output logic [7:0]                     M_AXI_ARLEN,
  input  logic [AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
  input  logic [1:0]                     M_AXI_RRESP,
  input  logic                           M_AXI_RVALID,
  output logic                           M_AXI_RREADY,
  input  logic [AXI_ID_WIDTH-1:0]        M_AXI_RID,
  input  logic                           M_AXI_RLAST
);

  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(BURST_LEN * BYTES);
  localparam int PTRW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] LINE_MASK = {AXI_ADDR_WIDTH{1'b1}} << OFFW;
  localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_PEND,
    SLOT_BUSY
  } slot_t;

  slot_t                     slot_q [NREQ];
  slot_t                     slot_d [NREQ];
  logic [7:0]                cnt_q  [NREQ];
  logic [7:0]                cnt_d  [NREQ];
  logic [AXI_ADDR_WIDTH-1:0] addr_q [NREQ];

  logic                      arvalid_q;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q;
  logic [AXI_ID_WIDTH-1:0]   arid_q;
  logic [PTRW-1:0]           rr_ptr_q;
  logic [PTRW-1:0]           rr_nxt;
  logic                      ar_hs;
  logic                      grant_vld;
  logic [PTRW-1:0]           grant_idx;

  logic [NREQ-1:0]           route_hit;
  logic                      route_err;

  logic [NREQ-1:0]           rsp_valid_q;
  logic [AXI_DATA_WIDTH-1:0] rsp_data_q;
  logic                      rsp_last_q;
  logic                      rsp_err_q;
  logic                      stray_q;

  logic                      unused_rresp0;

  assign unused_rresp0 = M_AXI_RRESP[0];
  assign ar_hs         = arvalid_q & M_AXI_ARREADY;

  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARID    = arid_q;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARSIZE  = 3'($clog2(BYTES));
  assign M_AXI_ARLEN   = LAST_CNT;
  assign M_AXI_RREADY  = 1'b1;

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;
  assign stray_rid = stray_q;

  // A slot is free to accept a new request only when idle
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = (slot_q[i] == SLOT_IDLE);
    end
  end

  // Per-slot state register, beat counter and line-aligned address capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        slot_q[i] <= SLOT_IDLE;
        cnt_q[i]  <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        slot_q[i] <= slot_d[i];
        cnt_q[i]  <= cnt_d[i];
        if (req_valid[i] && slot_q[i] == SLOT_IDLE) begin
          addr_q[i] <= req_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH] & LINE_MASK;
        end
      end
    end
  end

  // Slot next state and R-beat routing. A beat arriving in the same cycle as its
  // slot's AR handshake is accepted as beat 0, so the handshake is folded in first.
  always_comb begin
    logic       hs_i;
    logic [7:0] cnt_eff;
    route_hit = '0;
    route_err = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      slot_d[i] = slot_q[i];
      cnt_d[i]  = cnt_q[i];
      hs_i      = ar_hs && (arid_q == AXI_ID_WIDTH'(i));
      cnt_eff   = hs_i ? 8'd0 : cnt_q[i];
      if (slot_q[i] == SLOT_IDLE && req_valid[i]) begin
        slot_d[i] = SLOT_PEND;
      end
      if (hs_i) begin
        slot_d[i] = SLOT_BUSY;
        cnt_d[i]  = '0;
      end
      if (M_AXI_RVALID && (M_AXI_RID == AXI_ID_WIDTH'(i)) &&
          (slot_q[i] == SLOT_BUSY || hs_i)) begin
        route_hit[i] = 1'b1;
        cnt_d[i]     = cnt_eff + 8'd1;
        route_err    = M_AXI_RRESP[1] | (M_AXI_RLAST ^ (cnt_eff == LAST_CNT));
        if (M_AXI_RLAST) begin
          slot_d[i] = SLOT_IDLE;
        end
      end
    end
  end

  // Round-robin pick: first pending slot at or after rr_ptr, then wrap around
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!grant_vld && slot_q[i] == SLOT_PEND && i >= 32'(rr_ptr_q)) begin
        grant_vld = 1'b1;
        grant_idx = PTRW'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!grant_vld && slot_q[i] == SLOT_PEND) begin
        grant_vld = 1'b1;
        grant_idx = PTRW'(i);
      end
    end
    rr_nxt = (arid_q == AXI_ID_WIDTH'(NREQ - 1)) ? '0 : PTRW'(arid_q + 1'b1);
  end

  // AR channel register: launch a grant when idle, hold until ARREADY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arid_q    <= '0;
      rr_ptr_q  <= '0;
    end else if (ar_hs) begin
      arvalid_q <= 1'b0;
      rr_ptr_q  <= rr_nxt;
    end else if (!arvalid_q && grant_vld) begin
      arvalid_q <= 1'b1;
      araddr_q  <= addr_q[grant_idx];
      arid_q    <= AXI_ID_WIDTH'(grant_idx);
    end
  end

  // Registered response path; beats with no busy owner only set the sticky flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      stray_q     <= 1'b0;
    end else begin
      rsp_valid_q <= route_hit;
      if (|route_hit) begin
        rsp_data_q <= M_AXI_RDATA;
        rsp_last_q <= M_AXI_RLAST;
        rsp_err_q  <= route_err;
      end else begin
        rsp_last_q <= 1'b0;
        rsp_err_q  <= 1'b0;
      end
      if (M_AXI_RVALID && !(|route_hit)) begin
        stray_q <= 1'b1;
      end
    end
  end

endmodule
